// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the 2-read/1-write integer
// register file.
//   state_t        init sequencer state (INIT clears the array, RUN serves)
//   XLEN_DEFAULT   default register width
//   NREGS_DEFAULT  default number of architectural registers
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one synchronous read port of the register file.
// Masks x0 and out-of-range indices to zero, optionally forwards same-edge
// write data, and owns the registered data/valid outputs.
// Build option: REGFILE_BYPASS_EN selects write-first collision behaviour
// (undefined: read-first, and the write-port inputs are not present).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   run           register file is in RUN (requests accepted)
//   en, addr      read request and index
//   mem_word      array word at addr (don't-care when addr is out of range)
//   we, waddr,
//   wdata         effective write port (REGFILE_BYPASS_EN only)
//   data, valid   registered read result, 1-cycle latency
module regfile_read_port #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] mem_word,
`ifdef REGFILE_BYPASS_EN
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
`endif
  output logic [XLEN-1:0] data,
  output logic            valid
);

  logic            addr_ok;
  logic [XLEN-1:0] rd_word;

  assign addr_ok = (addr != '0) && (int'(addr) < NREGS);

  always_comb begin
    rd_word = '0;
    if (addr_ok) begin
      rd_word = mem_word;
`ifdef REGFILE_BYPASS_EN
      // we is already qualified (RUN, nonzero, in range) by the top.
      if (we && (waddr == addr))
        rd_word = wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (!run) begin
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en)
        data <= rd_word;
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: parametrised integer register file with two
// registered read ports and one write port; x0 reads as zero.
// After reset an init sequencer clears one entry per cycle (NREGS cycles),
// so the array itself carries no reset and can map to RAM.
// Build option: REGFILE_BYPASS_EN -> same-edge read/write of one address
// returns the written data; otherwise the pre-write value.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   ready                  init finished, requests accepted
//   rs1_en/addr/data/valid read port 1 (data registered, 1-cycle latency)
//   rs2_en/addr/data/valid read port 2
//   rd_we/addr/data        write port
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic            rs1_en,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_valid,
  input  logic            rs2_en,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_valid,
  input  logic            rd_we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state;
  logic [AW-1:0]   init_idx;
  logic [XLEN-1:0] mem [NREGS];

  logic            run;
  logic            wr_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [AW-1:0]   rs1_idx;
  logic [AW-1:0]   rs2_idx;
  logic [XLEN-1:0] rs1_word;
  logic [XLEN-1:0] rs2_word;

  assign run = (state == RUN);

  // Init sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_idx <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + AW'(1);
          if (init_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase
    end
  end

  // Architectural writes to x0 or beyond NREGS are dropped here, so the
  // read ports only see qualified writes for their bypass compare.
  assign wr_ok = run && rd_we && (rd_addr != '0) && (int'(rd_addr) < NREGS);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rd_addr;
    mem_wdata = rd_data;
    if (!reset) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_idx;
        mem_wdata = '0;
      end else begin
        mem_we = wr_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Clamp the index so the array is never accessed out of bounds; the read
  // ports force out-of-range results to zero anyway.
  assign rs1_idx  = (int'(rs1_addr) < NREGS) ? rs1_addr : '0;
  assign rs2_idx  = (int'(rs2_addr) < NREGS) ? rs2_addr : '0;
  assign rs1_word = mem[rs1_idx];
  assign rs2_word = mem[rs2_idx];

  regfile_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rs1 (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .en       (rs1_en),
    .addr     (rs1_addr),
    .mem_word (rs1_word),
`ifdef REGFILE_BYPASS_EN
    .we       (wr_ok),
    .waddr    (rd_addr),
    .wdata    (rd_data),
`endif
    .data     (rs1_data),
    .valid    (rs1_valid)
  );

  regfile_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rs2 (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .en       (rs2_en),
    .addr     (rs2_addr),
    .mem_word (rs2_word),
`ifdef REGFILE_BYPASS_EN
    .we       (wr_ok),
    .waddr    (rd_addr),
    .wdata    (rd_data),
`endif
    .data     (rs2_data),
    .valid    (rs2_valid)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
module tb_register_file_2r1w;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Instance a: defaults (XLEN=64, NREGS=32)
  logic        a_ready;
  logic        a_rs1_en, a_rs2_en, a_rd_we;
  logic [4:0]  a_rs1_addr, a_rs2_addr, a_rd_addr;
  logic [63:0] a_rs1_data, a_rs2_data, a_rd_data;
  logic        a_rs1_valid, a_rs2_valid;

  // Instance b: XLEN=32, NREGS=16
  logic        b_ready;
  logic        b_rs1_en, b_rs2_en, b_rd_we;
  logic [3:0]  b_rs1_addr, b_rs2_addr, b_rd_addr;
  logic [31:0] b_rs1_data, b_rs2_data, b_rd_data;
  logic        b_rs1_valid, b_rs2_valid;

  // Instance c: XLEN=16, NREGS=20 (non-power-of-two, out-of-range indices)
  logic        c_ready;
  logic        c_rs1_en, c_rs2_en, c_rd_we;
  logic [4:0]  c_rs1_addr, c_rs2_addr, c_rd_addr;
  logic [15:0] c_rs1_data, c_rs2_data, c_rd_data;
  logic        c_rs1_valid, c_rs2_valid;

  register_file_2r1w dut_a (
    .clk(clk), .reset(reset), .ready(a_ready),
    .rs1_en(a_rs1_en), .rs1_addr(a_rs1_addr), .rs1_data(a_rs1_data), .rs1_valid(a_rs1_valid),
    .rs2_en(a_rs2_en), .rs2_addr(a_rs2_addr), .rs2_data(a_rs2_data), .rs2_valid(a_rs2_valid),
    .rd_we(a_rd_we), .rd_addr(a_rd_addr), .rd_data(a_rd_data)
  );

  register_file_2r1w #(.XLEN(32), .NREGS(16)) dut_b (
    .clk(clk), .reset(reset), .ready(b_ready),
    .rs1_en(b_rs1_en), .rs1_addr(b_rs1_addr), .rs1_data(b_rs1_data), .rs1_valid(b_rs1_valid),
    .rs2_en(b_rs2_en), .rs2_addr(b_rs2_addr), .rs2_data(b_rs2_data), .rs2_valid(b_rs2_valid),
    .rd_we(b_rd_we), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  register_file_2r1w #(.XLEN(16), .NREGS(20)) dut_c (
    .clk(clk), .reset(reset), .ready(c_ready),
    .rs1_en(c_rs1_en), .rs1_addr(c_rs1_addr), .rs1_data(c_rs1_data), .rs1_valid(c_rs1_valid),
    .rs2_en(c_rs2_en), .rs2_addr(c_rs2_addr), .rs2_data(c_rs2_data), .rs2_valid(c_rs2_valid),
    .rd_we(c_rd_we), .rd_addr(c_rd_addr), .rd_data(c_rd_data)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] COLLIDE_EXP = 64'd2;
`else
  localparam logic [63:0] COLLIDE_EXP = 64'd1;
`endif

  initial begin
    int ca, cb, cc;

    reset = 1'b1;
    a_rs1_en = 0; a_rs2_en = 0; a_rd_we = 0;
    a_rs1_addr = '0; a_rs2_addr = '0; a_rd_addr = '0; a_rd_data = '0;
    b_rs1_en = 0; b_rs2_en = 0; b_rd_we = 0;
    b_rs1_addr = '0; b_rs2_addr = '0; b_rd_addr = '0; b_rd_data = '0;
    c_rs1_en = 0; c_rs2_en = 0; c_rd_we = 0;
    c_rs1_addr = '0; c_rs2_addr = '0; c_rd_addr = '0; c_rd_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready",  64'(a_ready),     64'd0);
    check("rst_valid1", 64'(a_rs1_valid), 64'd0);
    check("rst_valid2", 64'(a_rs2_valid), 64'd0);
    check("rst_data1",  a_rs1_data,       64'd0);
    check("rst_data2",  a_rs2_data,       64'd0);

    // Init length per instance, edges counted from reset release
    reset = 1'b0;
    ca = -1; cb = -1; cc = -1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (ca < 0 && a_ready) ca = t;
      if (cb < 0 && b_ready) cb = t;
      if (cc < 0 && c_ready) cc = t;
      if (ca >= 0 && cb >= 0 && cc >= 0) break;
    end
    check("init_len_a", 64'(ca), 64'd32);
    check("init_len_b", 64'(cb), 64'd16);
    check("init_len_c", 64'(cc), 64'd20);

    // Read all 32 entries, pipelined, port 2 walking the other way
    for (int i = 0; i < 32; i++) begin
      a_rs1_en = 1; a_rs1_addr = 5'(i);
      a_rs2_en = 1; a_rs2_addr = 5'(31 - i);
      tick();
      check($sformatf("init_rd1_%0d", i),  a_rs1_data,       64'd0);
      check($sformatf("init_v1_%0d", i),   64'(a_rs1_valid), 64'd1);
      check($sformatf("init_v2_%0d", i),   64'(a_rs2_valid), 64'd1);
    end
    a_rs1_en = 0; a_rs2_en = 0;

    // Write x5 then read on both ports
    a_rd_we = 1; a_rd_addr = 5'd5; a_rd_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    check("idle_valid", 64'(a_rs1_valid), 64'd0);
    a_rd_we = 0;
    a_rs1_en = 1; a_rs1_addr = 5'd5;
    a_rs2_en = 1; a_rs2_addr = 5'd5;
    tick();
    check("x5_rd1", a_rs1_data, 64'hDEADBEEF_CAFEF00D);
    check("x5_rd2", a_rs2_data, 64'hDEADBEEF_CAFEF00D);

    // x0 write is discarded
    a_rs1_en = 0; a_rs2_en = 0;
    a_rd_we = 1; a_rd_addr = 5'd0; a_rd_data = '1;
    tick();
    a_rd_we = 0;
    a_rs1_en = 1; a_rs1_addr = 5'd0;
    a_rs2_en = 1; a_rs2_addr = 5'd0;
    tick();
    check("x0_rd1", a_rs1_data, 64'd0);
    check("x0_rd2", a_rs2_data, 64'd0);

    // Same-edge read/write collision on x7
    a_rs1_en = 0; a_rs2_en = 0;
    a_rd_we = 1; a_rd_addr = 5'd7; a_rd_data = 64'd1;
    tick();
    a_rd_data = 64'd2;
    a_rs1_en = 1; a_rs1_addr = 5'd7;
    tick();
    check("collide_rd", a_rs1_data, COLLIDE_EXP);
    a_rd_we = 0;
    a_rs2_en = 1; a_rs2_addr = 5'd7;
    tick();
    check("after_rd1", a_rs1_data, 64'd2);
    check("after_rd2", a_rs2_data, 64'd2);

    // Disabled port holds its data, valid drops
    a_rs1_en = 0; a_rs1_addr = 5'd5;
    a_rs2_en = 0;
    tick();
    check("hold_data", a_rs1_data,       64'd2);
    check("hold_val",  64'(a_rs1_valid), 64'd0);

    // XLEN=32, NREGS=16: x15 round trip
    b_rd_we = 1; b_rd_addr = 4'd15; b_rd_data = 32'h1234_5678;
    tick();
    b_rd_we = 0;
    b_rs1_en = 1; b_rs1_addr = 4'd15;
    b_rs2_en = 1; b_rs2_addr = 4'd15;
    tick();
    check("b_x15_rd1", 64'(b_rs1_data), 64'h1234_5678);
    check("b_x15_rd2", 64'(b_rs2_data), 64'h1234_5678);
    check("b_valid",   64'(b_rs1_valid), 64'd1);
    b_rs1_en = 0; b_rs2_en = 0;

    // NREGS=20: last valid entry works, out-of-range writes/reads give 0
    c_rd_we = 1; c_rd_addr = 5'd19; c_rd_data = 16'hBEEF;
    tick();
    c_rd_addr = 5'd25; c_rd_data = 16'h1111;
    tick();
    c_rd_we = 0;
    c_rs1_en = 1; c_rs1_addr = 5'd19;
    c_rs2_en = 1; c_rs2_addr = 5'd25;
    tick();
    check("c_x19",     64'(c_rs1_data),  64'hBEEF);
    check("c_oor_rd",  64'(c_rs2_data),  64'd0);
    check("c_oor_val", 64'(c_rs2_valid), 64'd1);
    c_rs1_en = 0; c_rs2_en = 0;

    // Reset mid-run on instance a: x3=9, then reset with a read in flight
    a_rd_we = 1; a_rd_addr = 5'd3; a_rd_data = 64'd9;
    tick();
    a_rd_we = 0;
    a_rs1_en = 1; a_rs1_addr = 5'd3;
    tick();
    check("x3_pre", a_rs1_data, 64'd9);
    for (int i = 0; i < 8; i++) tick();
    a_rs1_en = 1; a_rs2_en = 1; a_rs2_addr = 5'd3;
    reset = 1'b1;
    tick();
    check("mrst_ready", 64'(a_ready),     64'd0);
    check("mrst_v1",    64'(a_rs1_valid), 64'd0);
    check("mrst_v2",    64'(a_rs2_valid), 64'd0);
    reset = 1'b0;
    // Requests and writes during INIT are ignored
    a_rd_we = 1; a_rd_addr = 5'd3; a_rd_data = 64'd77;
    ca = -1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      check($sformatf("init2_v1_%0d", t), 64'(a_rs1_valid), 64'd0);
      if (a_ready) begin
        ca = t;
        break;
      end
    end
    check("init2_len", 64'(ca), 64'd32);
    a_rd_we = 0;
    tick();
    check("x3_cleared", a_rs1_data,       64'd0);
    check("x3_valid",   64'(a_rs1_valid), 64'd1);
    a_rs1_en = 0; a_rs2_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
